// File: rtl/spi_slave_rx_if.sv
// Bundles the SPI pins and the parallel receive/response side of spi_slave_rx.
// The slave modport is the receiver's view. The master modport is the far end, either a link master or a bench.
interface spi_slave_rx_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sclk, cs, mosi, tx_data,
        output miso, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output sclk, cs, mosi, tx_data,
        input  miso, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave, oversampled in the clk domain: assembles MSB-first words from mosi,
// pulses rx_valid per word, flags aborted words, and shifts a response word out on miso.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronizer chains; new samples enter at bit 0, the settled value leaves at the top.
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t            state, state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic [DATA_W-1:0] rx_data, rx_data_n;
    logic [DATA_W-1:0] rx_word;
    logic              rx_valid, rx_valid_n;
    logic              frame_err, frame_err_n;
    logic              last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx_shift  <= rx_shift_n;
            tx_shift  <= tx_shift_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        rx_shift_n  = rx_shift;
        tx_shift_n  = tx_shift;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        rx_word     = {rx_shift[DATA_W-2:0], mosi_s};
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    tx_shift_n = bus.tx_data;
                    bit_cnt_n  = '0;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_n = rx_word;
                    if (last_bit) begin
                        rx_data_n  = rx_word;
                        rx_valid_n = 1'b1;
                        bit_cnt_n  = '0;
                        tx_shift_n = bus.tx_data;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    tx_shift_n = tx_shift << 1;
                end
                // The edge above is applied first, so a word completed in this cycle is not an abort.
                if (cs_rise) begin
                    state_n     = IDLE;
                    frame_err_n = (bit_cnt_n != '0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy      = (state == SHIFT);
    assign bus.miso      = (state == SHIFT) & tx_shift[DATA_W-1];
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.frame_err = frame_err;
endmodule
